// File: rtl/ntt_stream_host.sv
// ntt_stream_host: packs a word stream into NTT core memory rows, starts the core, streams results back; NTT_HOST_CYCLE_COUNT_EN adds cycle_count
module ntt_stream_host #(
    parameter int WIDTH = 32,
    parameter int SIZE = 257,
    parameter int ROWS = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [5:0]              cmd_mod_idx,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WIDTH-1:0]        s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic                    ntt_start,
    output logic [5:0]              ntt_mod_idx,
    output logic                    ntt_mem_read,
    output logic                    ntt_mem_write,
    output logic [8*SIZE-1:0]       ntt_mem_addr,
    output logic [WIDTH*SIZE-1:0]   ntt_din,
    input  logic [WIDTH*SIZE-1:0]   ntt_dout,
    input  logic                    ntt_done,
`ifdef NTT_HOST_CYCLE_COUNT_EN
    output logic [31:0]             cycle_count,
`endif
    output logic                    busy
);
    localparam int LW = $clog2(SIZE);
    localparam int RW = $clog2(READ_LATENCY) + 1;
    // one-hot states so every control output is a state flop bit
    typedef enum logic [6:0] {
        IDLE  = 7'b0000001,
        LOAD  = 7'b0000010,
        WRITE = 7'b0000100,
        START = 7'b0001000,
        WAIT  = 7'b0010000,
        RREQ  = 7'b0100000,
        DRAIN = 7'b1000000
    } state_t;
    state_t state;
    logic [WIDTH*SIZE-1:0] row_buf;
    logic [LW-1:0] lane;
    logic [7:0] row;
    logic [RW-1:0] rcnt;
    logic last_lane, last_row;
    assign last_lane = lane == LW'(SIZE - 1);
    assign last_row = row == 8'(ROWS - 1);
    assign cmd_ready = state[0];
    assign busy = !state[0];
    assign s_ready = state[1];
    assign ntt_mem_write = state[2];
    assign ntt_start = state[3];
    assign ntt_mem_read = state[5];
    assign m_valid = state[6];
    assign ntt_din = row_buf;
    assign ntt_mem_addr = (ntt_mem_read || ntt_mem_write) ? {SIZE{row}} : '0;
    assign m_data = row_buf[int'(lane)*WIDTH +: WIDTH];
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            row_buf <= '0;
            lane <= '0;
            row <= '0;
            rcnt <= '0;
            ntt_mod_idx <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    ntt_mod_idx <= cmd_mod_idx;
                    row <= '0;
                    lane <= '0;
                    state <= LOAD;
                end
                LOAD: if (s_valid) begin
                    row_buf[int'(lane)*WIDTH +: WIDTH] <= s_data;
                    lane <= lane + 1'b1;
                    if (last_lane) state <= WRITE;
                end
                WRITE: begin
                    row <= row + 1'b1;
                    lane <= '0;
                    state <= last_row ? START : LOAD;
                end
                START: state <= WAIT;
                WAIT: if (ntt_done) begin
                    row <= '0;
                    rcnt <= '0;
                    state <= RREQ;
                end
                RREQ: if (rcnt == RW'(READ_LATENCY - 1)) begin
                    row_buf <= ntt_dout;
                    lane <= '0;
                    state <= DRAIN;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
                DRAIN: if (m_ready) begin
                    lane <= last_lane ? '0 : lane + 1'b1;
                    if (last_lane) begin
                        row <= last_row ? row : row + 1'b1;
                        rcnt <= '0;
                        state <= last_row ? IDLE : RREQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef NTT_HOST_CYCLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset || state == START) cycle_count <= '0;
        else if (state == WAIT && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_ntt_stream_host.sv
// tb_ntt_stream_host: scoreboard bench for ntt_stream_host against an echoing core-memory model
module tb_ntt_stream_host;
    localparam int WIDTH = 32, SIZE = 257, ROWS = 2, RL = 2, TOTAL = SIZE * ROWS;
    logic clk = 0, reset = 1, cmd_valid = 0, s_valid = 0, m_ready = 0;
    logic cmd_ready, s_ready, m_valid, ntt_start, ntt_mem_read, ntt_mem_write, ntt_done, busy;
    logic [5:0] cmd_mod_idx = 0, ntt_mod_idx;
    logic [WIDTH-1:0] s_data = 0, m_data;
    logic [8*SIZE-1:0] ntt_mem_addr;
    logic [WIDTH*SIZE-1:0] ntt_din, ntt_dout;
`ifdef NTT_HOST_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif
    logic [WIDTH*SIZE-1:0] mem [ROWS];
    int dc = 0;
    int checks = 0, failures = 0;
    logic [WIDTH-1:0] q[$];
    typedef struct {
        logic [5:0] mod_idx;
        bit gaps;
        bit toggle;
        bit cmd_wait;
        logic [WIDTH-1:0] base;
        logic [WIDTH-1:0] row0_last;
        logic [WIDTH-1:0] row1_first;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    ntt_stream_host #(.WIDTH(WIDTH), .SIZE(SIZE), .ROWS(ROWS), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mod_idx(cmd_mod_idx),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ntt_start(ntt_start), .ntt_mod_idx(ntt_mod_idx),
        .ntt_mem_read(ntt_mem_read), .ntt_mem_write(ntt_mem_write),
        .ntt_mem_addr(ntt_mem_addr), .ntt_din(ntt_din), .ntt_dout(ntt_dout),
        .ntt_done(ntt_done),
`ifdef NTT_HOST_CYCLE_COUNT_EN
        .cycle_count(cycle_count),
`endif
        .busy(busy)
    );

    always @(posedge clk) begin
        if (ntt_mem_write) mem[ntt_mem_addr[0]] <= ntt_din;
        if (ntt_mem_read) ntt_dout <= mem[ntt_mem_addr[0]];
        if (ntt_start) dc <= 1;
        else if (dc != 0 && dc < 60) dc <= dc + 1;
    end
    assign ntt_done = dc == 50;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int sidx = 0, ocnt = 0, wr_n = 0, st_n = 0, last_wr = 0, st_cyc = -100;
        int rd_wait = 0, overlap = 0, cyc, bad = 0;
        int rd_cnt [ROWS];
        logic [7:0] wr_row [2];
        logic [5:0] st_mod = 0;
        logic [WIDTH-1:0] prev_data = 0, e;
        bit in_wait = 0, prev_stall = 0, cmd_checked = 0;
        for (int r = 0; r < ROWS; r++) rd_cnt[r] = 0;
        wr_row[0] = 8'hFF;
        wr_row[1] = 8'hFF;
        q.delete();
        cmd_mod_idx = v.mod_idx;
        cmd_valid = 1;
        step();
        cmd_valid = 0;
        cmd_mod_idx = ~v.mod_idx;
        for (cyc = 0; cyc < 20000; cyc++) begin
            if (ocnt == TOTAL && cmd_ready) break;
            s_valid = (sidx < TOTAL) && (!v.gaps || $urandom_range(0, 1) == 1);
            s_data = v.base + WIDTH'(sidx);
            m_ready = !v.toggle || (cyc % 2 == 0);
            cmd_valid = v.cmd_wait && in_wait;
            if (cmd_valid && !cmd_checked) begin
                check("cmd_ready_in_wait", cmd_ready, 0);
                cmd_checked = 1;
            end
            if (ntt_mem_write) begin
                if (wr_n < 2) wr_row[wr_n] = ntt_mem_addr[7:0];
                wr_n++;
                last_wr = cyc;
            end
            if (ntt_start) begin
                st_n++;
                st_cyc = cyc;
                st_mod = ntt_mod_idx;
            end
            if (ntt_mem_read && ntt_mem_write) overlap++;
            if (ntt_mem_read && in_wait) rd_wait++;
            if (ntt_mem_read && ntt_mem_addr[7:0] < ROWS) rd_cnt[ntt_mem_addr[7:0]]++;
            if (prev_stall) check("m_data_stall", m_data, prev_data);
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            if (s_valid && s_ready) begin
                q.push_back(s_data);
                sidx++;
            end
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_extra_word vec=%0d actual=%0h required=none", n, m_data);
                end else begin
                    e = q.pop_front();
                    check("m_data", m_data, e);
                end
                ocnt++;
            end
            if (ntt_done) in_wait = 0;
            if (ntt_start) in_wait = 1;
            step();
        end
        cmd_valid = 0;
        s_valid = 0;
        m_ready = 0;
        check("completed", cyc < 20000, 1);
        check("words_out", ocnt, TOTAL);
        check("sb_empty", q.size(), 0);
        check("writes", wr_n, 2);
        check("wr_row0", wr_row[0], 0);
        check("wr_row1", wr_row[1], 1);
        check("starts", st_n, 1);
        check("start_after_write", st_cyc - last_wr, 1);
        check("start_mod", st_mod, v.mod_idx);
        check("mod_held", ntt_mod_idx, v.mod_idx);
        check("row0_lane256", mem[0][256*WIDTH +: WIDTH], v.row0_last);
        check("row1_lane0", mem[1][0 +: WIDTH], v.row1_first);
        for (int r = 0; r < ROWS; r++)
            for (int l = 0; l < SIZE; l++)
                if (mem[r][l*WIDTH +: WIDTH] !== v.base + WIDTH'(r*SIZE + l)) bad++;
        check("mem_contents", bad, 0);
        check("rd_row0", rd_cnt[0], RL);
        check("rd_row1", rd_cnt[1], RL);
        check("rd_in_wait", rd_wait, 0);
        check("rd_wr_overlap", overlap, 0);
        check("idle_busy", busy, 0);
        check("idle_m_valid", m_valid, 0);
`ifdef NTT_HOST_CYCLE_COUNT_EN
        check("cycle_count", cycle_count, 50);
`endif
    endtask

    initial begin
        int wrs = 0;
        vecs[0] = '{6'd5,  1'b0, 1'b0, 1'b0, 32'd0,          32'd256,        32'd257};
        vecs[1] = '{6'd17, 1'b1, 1'b0, 1'b1, 32'd0,          32'd256,        32'd257};
        vecs[2] = '{6'd63, 1'b0, 1'b1, 1'b0, 32'h1000,       32'h1100,       32'h1101};
        vecs[3] = '{6'd0,  1'b1, 1'b1, 1'b1, 32'hA5A50000,   32'hA5A50100,   32'hA5A50101};
        reset = 1;
        step();
        step();
        reset = 0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_start", ntt_start, 0);
        check("rst_read", ntt_mem_read, 0);
        check("rst_write", ntt_mem_write, 0);
        check("rst_m_data", m_data, 0);
        check("rst_mod_idx", ntt_mod_idx, 0);
        check("rst_addr_nonzero", ntt_mem_addr != 0, 0);
`ifdef NTT_HOST_CYCLE_COUNT_EN
        check("rst_cycle_count", cycle_count, 0);
`endif
        cmd_mod_idx = 6'd9;
        cmd_valid = 1;
        step();
        cmd_valid = 0;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1;
            s_data = 32'hDEAD0000 + WIDTH'(i);
            if (ntt_mem_write) wrs++;
            step();
        end
        s_valid = 0;
        reset = 1;
        step();
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_write", ntt_mem_write, 0);
        check("abort_m_valid", m_valid, 0);
        check("abort_s_ready", s_ready, 0);
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            if (ntt_mem_write || ntt_start || ntt_mem_read) wrs++;
            step();
        end
        check("abort_no_activity", wrs, 0);
        for (int n = 0; n < 4; n++) run_vec(n, vecs[n]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ntt_stream_host.md
Name: ntt_stream_host

Overview:
- Host-side initiator for the wide NTT core. Sits between a narrow word stream and the core's memory-load/start/done interface.
- Packs a serial stream of WIDTH-bit coefficients into SIZE-lane rows, writes ROWS rows into the core memory, then pulses start with the selected modulus index.
- After done, reads the rows back and serializes the result onto an output stream.

Parameters:
- WIDTH, 32, coefficient width in bits
- SIZE, 257, lanes per memory row; 2..257
- ROWS, 256, rows per transform; 1..256, row index is 8 bits
- READ_LATENCY, 2, cycles from mem_read/mem_addr to valid mem_dout; ≥1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  request to run one transform
- cmd_ready  out  1  high only in IDLE
- cmd_mod_idx  in  6  modulus index, captured on cmd handshake
- s_valid  in  1  input coefficient valid
- s_ready  out  1  input coefficient accepted when s_valid&s_ready
- s_data  in  WIDTH  input coefficient
- m_valid  out  1  output coefficient valid
- m_ready  in  1  downstream accepts
- m_data  out  WIDTH  output coefficient
- ntt_start  out  1  one-cycle start pulse to core
- ntt_mod_idx  out  6  modulus index, held from capture
- ntt_mem_read  out  1  host read of core memory
- ntt_mem_write  out  1  host write of core memory
- ntt_mem_addr  out  8*SIZE  per-lane row address; all lanes carry the same row
- ntt_din  out  WIDTH*SIZE  row data for write
- ntt_dout  in  WIDTH*SIZE  row data from core memory
- ntt_done  in  1  core completion
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. Row buffer and counters are cleared; FSM goes to IDLE.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_mod_idx into ntt_mod_idx, clear row/lane counters, go to LOAD.
- LOAD: s_ready=1 while lane<SIZE.
  - Accepted word k is placed in lane k, bits [(k+1)*WIDTH-1 -: WIDTH].
  - When lane SIZE-1 is accepted, go to WRITE. s_ready=0 in WRITE.
- WRITE (1 cycle): ntt_mem_write=1, ntt_din=buffer, ntt_mem_addr={SIZE{row}}.
  - Then increment row and clear lane.
  - If row was ROWS-1, go to START; otherwise return to LOAD.
- START (1 cycle): ntt_start=1, then go to WAIT.
- WAIT: ntt_mem_read and ntt_mem_write are 0 (the core owns memory). On the first cycle with ntt_done=1, clear row and go to RREQ.
- RREQ: ntt_mem_read=1 and ntt_mem_addr={SIZE{row}}, both held for READ_LATENCY cycles.
  - On the last of those cycles, capture ntt_dout into the buffer, then go to DRAIN.
  - mem_read is 0 in DRAIN.
- DRAIN: m_valid=1, m_data=buffer lane k, k from 0 upward.
  - m_data is stable while m_valid&!m_ready.
  - After lane SIZE-1 is accepted: if row==ROWS-1, go to IDLE; else increment row and go to RREQ.
- Never assert ntt_mem_read and ntt_mem_write together.
- s_valid outside LOAD is ignored; no data is lost, the producer holds.
- cmd_valid outside IDLE is ignored.
- ntt_done during LOAD/WRITE/START/RREQ/DRAIN is ignored.
- Reset in any state aborts immediately: partial rows are discarded and no further start/write/read is issued.
- Throughput: SIZE+1 cycles per loaded row (no back-pressure); SIZE+READ_LATENCY cycles per drained row (m_ready=1).

Optional Feature:
- Macro NTT_HOST_CYCLE_COUNT_EN.
- Defined: adds output port cycle_count [31:0].
  - Cleared to 0 on reset and in the START cycle.
  - Increments every WAIT cycle, saturating at 32'hFFFFFFFF.
  - Holds its value after leaving WAIT until the next START.
- Not defined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Bench config for all scenarios: SIZE=257, ROWS=2, READ_LATENCY=2.
- Reset mid-LOAD: after 100 words, assert reset → cmd_ready=1, busy=0, no ntt_mem_write, m_valid=0. A following full load writes row 0 from a fresh lane 0.
- Full load, mod_idx=5, s_data=0..513, s_valid=1:
  - ntt_mem_write pulses twice with rows 0 and 1; row 0 lane 256 = 256, row 1 lane 0 = 257.
  - ntt_start pulses once, exactly 1 cycle after the second write, with ntt_mod_idx=5.
- Core-model echo (ntt_dout = memory contents, done 50 cycles after start):
  - m_data emits 0..513 in order.
  - ntt_mem_read high exactly 2 cycles per row; never high in WAIT.
- Output back-pressure: toggle m_ready 1/0 every cycle → m_data unchanged across stalled cycles, 514 words total, no duplicates.
- Input gaps: s_valid random 50% → identical row contents to the full-rate load. cmd_valid pulsed during WAIT is ignored; cmd_ready stays 0.
- NTT_HOST_CYCLE_COUNT_EN defined, done 50 cycles after start → cycle_count reads 50, stable through DRAIN.
